// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - Avalon-MM SDRAM stand-in: local memory, fixed read latency, refresh stalls
module sdram_responder #(
    parameter int ADDR_BITS      = 8,
    parameter int READ_LATENCY   = 3,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [28:0] address,
    input  logic [7:0]  burstcount,
    output logic        waitrequest,
    input  logic        read,
    output logic [63:0] readdata,
    output logic        readdatavalid,
    input  logic        write,
    input  logic [63:0] writedata,
    input  logic [7:0]  byteenable,
    output logic [31:0] debug_value0,
    output logic [31:0] debug_value1
);

    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_WRITE_BURST = 4'd1,
        S_READ_WAIT   = 4'd2,
        S_READ_BURST  = 4'd3,
        S_REFRESH     = 4'd4
    } state_t;

    state_t                 r_state;
    logic [63:0]            r_mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0]   r_waddr;
    logic [7:0]             r_wrem;
    logic [ADDR_BITS-1:0]   r_raddr;
    logic [7:0]             r_rrem;
    logic [LW-1:0]          r_lat;
    logic [CW-1:0]          r_ref_left;
    logic [RW-1:0]          r_refresh_cnt;
    logic                   r_pending;
    logic [63:0]            r_readdata;
    logic                   r_readdatavalid;
    logic [15:0]            r_reads;
    logic [15:0]            r_writes;
    logic [7:0]             r_err;

    logic [ADDR_BITS-1:0]   w_cmd_addr;
    logic [ADDR_BITS-1:0]   w_mem_addr;
    logic [7:0]             w_beats;
    logic                   w_mem_we;
    logic                   w_refresh_tick;
    logic                   w_unused_addr;

    // Upper address bits alias onto the local array and are deliberately ignored
    assign w_unused_addr  = ^address[28:ADDR_BITS];
    assign w_cmd_addr     = address[ADDR_BITS-1:0];
    assign w_beats        = (burstcount == 8'd0) ? 8'd1 : burstcount;
    assign w_refresh_tick = (REFRESH_PERIOD != 0) && (r_refresh_cnt == RW'(REFRESH_PERIOD - 1));

    // The port stalls whenever a read owns it, refresh is running or about to start
    assign waitrequest = reset
                      || (r_state == S_READ_WAIT)
                      || (r_state == S_READ_BURST)
                      || (r_state == S_REFRESH)
                      || ((r_state == S_IDLE) && r_pending);

    // Write beats land at the command address first, then at the running burst address
    assign w_mem_addr = (r_state == S_WRITE_BURST) ? r_waddr : w_cmd_addr;
    assign w_mem_we   = write && !waitrequest
                     && ((r_state == S_IDLE) || (r_state == S_WRITE_BURST));

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign debug_value0  = {r_reads, r_writes};
    assign debug_value1  = {8'b0, r_err, 12'b0, r_state};

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Byte-masked write port; memory contents are intentionally not reset
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (byteenable[i]) begin
                    r_mem[w_mem_addr][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Free-running refresh interval counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
        end else if (w_refresh_tick) begin
            r_refresh_cnt <= '0;
        end else if (REFRESH_PERIOD != 0) begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Command FSM with registered read data, statistics and refresh pending flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_waddr         <= '0;
            r_wrem          <= '0;
            r_raddr         <= '0;
            r_rrem          <= '0;
            r_lat           <= '0;
            r_ref_left      <= '0;
            r_pending       <= 1'b0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_reads         <= '0;
            r_writes        <= '0;
            r_err           <= '0;
        end else begin
            r_readdatavalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_state    <= S_REFRESH;
                        r_ref_left <= CW'(REFRESH_CYCLES);
                    end else if (write) begin
                        // A simultaneous read is dropped in favour of the write
                        r_writes <= r_writes + 16'd1;
                        r_waddr  <= w_cmd_addr + 1'b1;
                        r_wrem   <= w_beats - 8'd1;
                        if (w_beats != 8'd1) begin
                            r_state <= S_WRITE_BURST;
                        end
                        if (read) begin
                            r_err <= sat_inc(r_err);
                        end
                    end else if (read) begin
                        r_reads <= r_reads + 16'd1;
                        r_raddr <= w_cmd_addr;
                        r_rrem  <= w_beats;
                        if (READ_LATENCY == 1) begin
                            r_state <= S_READ_BURST;
                        end else begin
                            r_state <= S_READ_WAIT;
                            r_lat   <= LW'(READ_LATENCY - 1);
                        end
                    end
                end
                S_WRITE_BURST: begin
                    if (read) begin
                        r_err <= sat_inc(r_err);
                    end
                    if (write) begin
                        r_waddr <= r_waddr + 1'b1;
                        r_wrem  <= r_wrem - 8'd1;
                        if (r_wrem == 8'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (r_lat == LW'(1)) begin
                        r_state <= S_READ_BURST;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_READ_BURST: begin
                    r_readdatavalid <= 1'b1;
                    r_readdata      <= r_mem[r_raddr];
                    r_raddr         <= r_raddr + 1'b1;
                    r_rrem          <= r_rrem - 8'd1;
                    if (r_rrem == 8'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFRESH: begin
                    if (r_ref_left == CW'(1)) begin
                        r_state   <= S_IDLE;
                        r_pending <= 1'b0;
                    end else begin
                        r_ref_left <= r_ref_left - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // A new refresh request wins over a same-edge clear
            if (w_refresh_tick) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed self-checking bench for sdram_responder
`timescale 1ns/1ps
module tb_sdram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        waitrequest;
    logic        rd;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic        wr;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic [31:0] dbg0;
    logic [31:0] dbg1;

    logic [28:0] rf_address;
    logic [7:0]  rf_burstcount;
    logic        rf_waitrequest;
    logic        rf_rd;
    logic [63:0] rf_readdata;
    logic        rf_readdatavalid;
    logic        rf_wr;
    logic [63:0] rf_writedata;
    logic [7:0]  rf_byteenable;
    logic [31:0] rf_dbg0;
    logic [31:0] rf_dbg1;

    int checks   = 0;
    int failures = 0;

    logic [63:0] rb [8];
    int          rb_n;
    int          rb_lat;
    logic        rb_gap;
    logic        rb_wr_after;

    always #5 clk = ~clk;

    sdram_responder #(.ADDR_BITS(8), .READ_LATENCY(3), .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)) dut (
        .clock(clk), .reset(rst), .address(address), .burstcount(burstcount),
        .waitrequest(waitrequest), .read(rd), .readdata(readdata), .readdatavalid(readdatavalid),
        .write(wr), .writedata(writedata), .byteenable(byteenable),
        .debug_value0(dbg0), .debug_value1(dbg1)
    );

    sdram_responder #(.ADDR_BITS(8), .READ_LATENCY(3), .REFRESH_PERIOD(16), .REFRESH_CYCLES(4)) dut_r (
        .clock(clk), .reset(rst), .address(rf_address), .burstcount(rf_burstcount),
        .waitrequest(rf_waitrequest), .read(rf_rd), .readdata(rf_readdata), .readdatavalid(rf_readdatavalid),
        .write(rf_wr), .writedata(rf_writedata), .byteenable(rf_byteenable),
        .debug_value0(rf_dbg0), .debug_value1(rf_dbg1)
    );

    task automatic apply_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0; rf_rd = 1'b0; rf_wr = 1'b0;
        address = '0; burstcount = 8'd1; writedata = '0; byteenable = 8'hFF;
        rf_address = '0; rf_burstcount = 8'd1; rf_writedata = '0; rf_byteenable = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic write_seq(input logic [28:0] a, input int n, input logic [63:0] first, input logic [7:0] be);
        address = a; burstcount = 8'(n); byteenable = be; wr = 1'b1;
        for (int k = 0; k < n; k++) begin
            writedata = first + 64'(k);
            @(posedge clk); #1;
        end
        wr = 1'b0;
    endtask

    task automatic read_seq(input logic [28:0] a, input logic [7:0] bc);
        int last_edge;
        rb_n = 0; rb_lat = -1; rb_gap = 1'b0; last_edge = -1;
        for (int i = 0; i < 8; i++) rb[i] = '0;
        address = a; burstcount = bc; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        rb_wr_after = waitrequest;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (readdatavalid) begin
                if (rb_n == 0) rb_lat = e;
                else if (last_edge != e - 1) rb_gap = 1'b1;
                if (rb_n < 8) rb[rb_n] = readdata;
                rb_n++;
                last_edge = e;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0; rf_rd = 1'b0; rf_wr = 1'b0;
        address = '0; burstcount = 8'd1; writedata = '0; byteenable = 8'hFF;
        rf_address = '0; rf_burstcount = 8'd1; rf_writedata = '0; rf_byteenable = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait_in_reset actual=%0h expected=1", waitrequest); end
        rst = 1'b0;
        #1;
        checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL reset_wait_after actual=%0h expected=0", waitrequest); end
        checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv actual=%0h expected=0", readdatavalid); end
        checks++; if (readdata !== 64'h0) begin failures++; $display("FAIL reset_rdata actual=%h expected=0", readdata); end
        checks++; if (dbg0 !== 32'h0) begin failures++; $display("FAIL reset_dbg0 actual=%h expected=0", dbg0); end
        checks++; if (dbg1 !== 32'h0) begin failures++; $display("FAIL reset_dbg1 actual=%h expected=0", dbg1); end
    endtask

    task automatic test_single();
        address = 29'h0700_0000; burstcount = 8'd1; writedata = 64'hDEAD_BEEF_CAFE_BABE; byteenable = 8'hFF; wr = 1'b1;
        checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL single_wr_wait actual=%0h expected=0", waitrequest); end
        @(posedge clk); #1;
        wr = 1'b0;
        checks++; if (dbg1[3:0] !== 4'd0) begin failures++; $display("FAIL single_wr_state actual=%0h expected=0", dbg1[3:0]); end
        read_seq(29'h0700_0000, 8'd1);
        checks++; if (rb_wr_after !== 1'b1) begin failures++; $display("FAIL single_rd_wait actual=%0h expected=1", rb_wr_after); end
        checks++; if (rb_lat != 3) begin failures++; $display("FAIL single_rd_latency actual=%0d expected=3", rb_lat); end
        checks++; if (rb_n != 1) begin failures++; $display("FAIL single_rd_beats actual=%0d expected=1", rb_n); end
        checks++; if (rb[0] !== 64'hDEAD_BEEF_CAFE_BABE) begin failures++; $display("FAIL single_rd_data actual=%h expected=deadbeefcafebabe", rb[0]); end
        checks++; if (dbg0 !== 32'h0001_0001) begin failures++; $display("FAIL single_counts actual=%h expected=00010001", dbg0); end
    endtask

    task automatic test_partial();
        write_seq(29'h10, 1, 64'h1111_1111_1111_1111, 8'hFF);
        write_seq(29'h10, 1, 64'h2222_2222_2222_2222, 8'h0F);
        read_seq(29'h10, 8'd1);
        checks++; if (rb[0] !== 64'h1111_1111_2222_2222) begin failures++; $display("FAIL partial_data actual=%h expected=1111111122222222", rb[0]); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_beat;
        write_seq(29'hFE, 4, 64'd1, 8'hFF);
        checks++; if (dbg1[3:0] !== 4'd0) begin failures++; $display("FAIL wrap_wr_state actual=%0h expected=0", dbg1[3:0]); end
        read_seq(29'hFE, 8'd4);
        checks++; if (rb_n != 4) begin failures++; $display("FAIL wrap_beats actual=%0d expected=4", rb_n); end
        checks++; if (rb_gap !== 1'b0) begin failures++; $display("FAIL wrap_gap actual=%0h expected=0", rb_gap); end
        for (int k = 0; k < 4; k++) begin
            exp_beat = 64'(k + 1);
            checks++; if (rb[k] !== exp_beat) begin failures++; $display("FAIL wrap_beat%0d actual=%h expected=%h", k, rb[k], exp_beat); end
        end
        read_seq(29'h01, 8'd1);
        checks++; if (rb[0] !== 64'd4) begin failures++; $display("FAIL wrap_word1 actual=%h expected=4", rb[0]); end
        read_seq(29'h1000_0101, 8'd1);
        checks++; if (rb[0] !== 64'd4) begin failures++; $display("FAIL alias_word1 actual=%h expected=4", rb[0]); end
        read_seq(29'hFF, 8'd0);
        checks++; if (rb_n != 1) begin failures++; $display("FAIL bc0_beats actual=%0d expected=1", rb_n); end
        checks++; if (rb[0] !== 64'd2) begin failures++; $display("FAIL bc0_data actual=%h expected=2", rb[0]); end
    endtask

    task automatic test_back_to_back();
        write_seq(29'h40, 2, 64'hA0, 8'hFF);
        checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL b2b_wr_done_wait actual=%0h expected=0", waitrequest); end
        address = 29'h40; burstcount = 8'd2; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (readdatavalid !== 1'b1 || readdata !== 64'hA0) begin failures++; $display("FAIL b2b_beat0 actual=%0h/%h expected=1/a0", readdatavalid, readdata); end
        @(posedge clk); #1;
        checks++; if (readdatavalid !== 1'b1 || readdata !== 64'hA1) begin failures++; $display("FAIL b2b_beat1 actual=%0h/%h expected=1/a1", readdatavalid, readdata); end
        checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL b2b_last_beat_wait actual=%0h expected=0", waitrequest); end
        address = 29'h42; burstcount = 8'd1; writedata = 64'hBEEF; byteenable = 8'hFF; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
        checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL b2b_extra_beat actual=%0h expected=0", readdatavalid); end
        checks++; if (dbg0 !== 32'h0007_0006) begin failures++; $display("FAIL b2b_counts actual=%h expected=00070006", dbg0); end
        read_seq(29'h42, 8'd1);
        checks++; if (rb[0] !== 64'hBEEF) begin failures++; $display("FAIL b2b_readback actual=%h expected=beef", rb[0]); end
    endtask

    task automatic test_conflict();
        apply_reset();
        address = 29'h5; burstcount = 8'd1; writedata = 64'h5555_0000_5555_0000; byteenable = 8'hFF;
        wr = 1'b1; rd = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        checks++; if (dbg1 !== 32'h0001_0000) begin failures++; $display("FAIL conflict_err actual=%h expected=00010000", dbg1); end
        checks++; if (dbg0 !== 32'h0000_0001) begin failures++; $display("FAIL conflict_counts actual=%h expected=00000001", dbg0); end
        read_seq(29'h5, 8'd1);
        checks++; if (rb_n != 1 || rb[0] !== 64'h5555_0000_5555_0000) begin failures++; $display("FAIL conflict_data actual=%0d/%h expected=1/5555000055550000", rb_n, rb[0]); end
        address = 29'h60; burstcount = 8'd2; writedata = 64'h60; wr = 1'b1;
        @(posedge clk); #1;
        checks++; if (dbg1[3:0] !== 4'd1) begin failures++; $display("FAIL wburst_state actual=%0h expected=1", dbg1[3:0]); end
        rd = 1'b1; writedata = 64'h61;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        checks++; if (dbg1 !== 32'h0002_0000) begin failures++; $display("FAIL wburst_read_err actual=%h expected=00020000", dbg1); end
        checks++; if (dbg0 !== 32'h0001_0002) begin failures++; $display("FAIL wburst_counts actual=%h expected=00010002", dbg0); end
    endtask

    task automatic test_reset_mid_burst();
        int late;
        write_seq(29'h20, 8, 64'h100, 8'hFF);
        address = 29'h20; burstcount = 8'd8; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (readdatavalid !== 1'b1 || readdata !== 64'h101) begin failures++; $display("FAIL midrst_beat1 actual=%0h/%h expected=1/101", readdatavalid, readdata); end
        #1 rst = 1'b1;
        #1;
        checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_rdv actual=%0h expected=0", readdatavalid); end
        checks++; if (dbg1[3:0] !== 4'd0) begin failures++; $display("FAIL midrst_state actual=%0h expected=0", dbg1[3:0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        late = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (readdatavalid) late++;
        end
        checks++; if (late != 0) begin failures++; $display("FAIL midrst_late_beats actual=%0d expected=0", late); end
        checks++; if (dbg0 !== 32'h0) begin failures++; $display("FAIL midrst_counts actual=%h expected=0", dbg0); end
    endtask

    task automatic test_refresh();
        int hi;
        int lat;
        logic [3:0] st;
        logic [63:0] got;
        apply_reset();
        @(posedge clk); #1;
        rf_address = 29'h9; rf_burstcount = 8'd1; rf_writedata = 64'h0123_4567_89AB_CDEF; rf_byteenable = 8'hFF; rf_wr = 1'b1;
        @(posedge clk); #1;
        rf_wr = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        checks++; if (rf_waitrequest !== 1'b0) begin failures++; $display("FAIL refresh_pre_wait actual=%0h expected=0", rf_waitrequest); end
        @(posedge clk); #1;
        checks++; if (rf_waitrequest !== 1'b1) begin failures++; $display("FAIL refresh_pending_wait actual=%0h expected=1", rf_waitrequest); end
        rf_address = 29'h9; rf_burstcount = 8'd1; rf_rd = 1'b1;
        hi = 0; st = 4'hF;
        while (rf_waitrequest && hi < 20) begin
            hi++;
            if (hi == 2) st = rf_dbg1[3:0];
            @(posedge clk); #1;
        end
        checks++; if (hi != 5) begin failures++; $display("FAIL refresh_stall_cycles actual=%0d expected=5", hi); end
        checks++; if (st !== 4'd4) begin failures++; $display("FAIL refresh_state actual=%0h expected=4", st); end
        @(posedge clk); #1;
        rf_rd = 1'b0;
        lat = -1; got = '0;
        for (int e = 1; e <= 10; e++) begin
            if (rf_readdatavalid && lat < 0) begin lat = e - 1; got = rf_readdata; end
            @(posedge clk); #1;
        end
        checks++; if (lat != 3) begin failures++; $display("FAIL refresh_rd_latency actual=%0d expected=3", lat); end
        checks++; if (got !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL refresh_rd_data actual=%h expected=0123456789abcdef", got); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_wrap();
        test_back_to_back();
        test_conflict();
        test_reset_mid_burst();
        test_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
